// File: rtl/pixel_frame_loader_pkg.sv
// Shared types and constants for the pixel frame loader.
package pixel_frame_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LAUNCH,
    BUSY,
    RELEASE
  } loader_state_t;

  localparam int NUM_PIXELS_DEFAULT = 900;
  localparam int PIXEL_W            = 8;

endpackage

// File: rtl/pixel_frame_loader.sv
// Pixel frame loader: takes an SOF-framed byte stream of grayscale pixels,
// writes one full frame into the pixel RAM, then runs the level start/done
// handshake with the inference controller. Single-buffered: input is blocked
// from the moment the frame is complete until the handshake finishes.
module pixel_frame_loader
  import pixel_frame_loader_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int ADDR_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [PIXEL_W-1:0] s_data,
  input  logic               s_sof,
  output logic               s_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIXEL_W-1:0] wr_data,
  output logic               layer_start,
  input  logic               layer_done,
  output logic               busy,
  output logic               frame_done,
  output logic               resync_err
);

  localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W + 1)'(NUM_PIXELS);

  loader_state_t   state;
  logic [ADDR_W:0] count;
  logic            accept;
  logic [ADDR_W:0] next_count;
  logic            frame_full;

  // A start-of-frame beat always restarts at pixel 0, so the count after it is 1.
  assign accept     = s_valid & s_ready;
  assign next_count = s_sof ? (ADDR_W + 1)'(1) : count + (ADDR_W + 1)'(1);
  assign frame_full = (next_count == FRAME_LEN);

  // Frame sequencing and controller handshake; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      s_ready     <= 1'b0;
      layer_start <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      resync_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          if (accept && s_sof) begin
            count <= next_count;
            busy  <= 1'b1;
            if (frame_full) begin
              state   <= LAUNCH;
              s_ready <= 1'b0;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            count <= next_count;
            if (s_sof) begin
              resync_err <= 1'b1;
            end
            if (frame_full) begin
              state   <= LAUNCH;
              s_ready <= 1'b0;
            end
          end
        end
        LAUNCH: begin
          layer_start <= 1'b1;
          state       <= BUSY;
        end
        BUSY: begin
          if (layer_done) begin
            layer_start <= 1'b0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          if (!layer_done) begin
            frame_done <= 1'b1;
            count      <= '0;
            busy       <= 1'b0;
            s_ready    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          count       <= '0;
          s_ready     <= 1'b0;
          layer_start <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Pixel RAM write stage: one cycle behind acceptance; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept && (s_sof || state == FILL);
      if (accept && (s_sof || state == FILL)) begin
        wr_addr <= s_sof ? '0 : count[ADDR_W-1:0];
        wr_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed testbench for pixel_frame_loader.
module tb_pixel_frame_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_sof = 1'b0;
  logic       s_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       layer_start;
  logic       layer_done = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       resync_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic start_prev  = 1'b0;
  int   start_rises = 0;

  pixel_frame_loader #(
    .NUM_PIXELS(900),
    .ADDR_W    (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .layer_start(layer_start),
    .layer_done (layer_done),
    .busy       (busy),
    .frame_done (frame_done),
    .resync_err (resync_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count rising edges of layer_start
  always @(negedge clk) begin
    start_prev <= layer_start;
    if (layer_start && !start_prev) start_rises <= start_rises + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present n beats (optionally with idle gaps) and check each write lands next cycle
  task automatic feed_beats(input int n, input bit sof_first, input int addr_start,
                            input bit bubbles, input string tag);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        s_valid = 1'b0;
        s_sof   = 1'b1;
        s_data  = 8'hEE;
        tick();
        n_checks++;
        if (wr_en !== 1'b0) $display("[TB] FAIL %s bubble_wr_en beat %0d: got %b want 0", tag, i, wr_en);
        else n_pass++;
      end
      s_valid = 1'b1;
      s_sof   = sof_first && (i == 0);
      s_data  = 8'(addr_start + i);
      n_checks++;
      if (s_ready !== 1'b1) $display("[TB] FAIL %s s_ready beat %0d: got %b want 1", tag, i, s_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'(addr_start + i) || wr_data !== 8'(addr_start + i))
        $display("[TB] FAIL %s write beat %0d: got en=%b addr=%0d data=%0d want en=1 addr=%0d data=%0d",
                 tag, i, wr_en, wr_addr, wr_data, addr_start + i, (addr_start + i) % 256);
      else n_pass++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Called right after the last-beat edge: input closes, start rises one cycle later
  task automatic expect_launch(input string tag);
    n_checks++;
    if (s_ready !== 1'b0 || layer_start !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL %s launch_cycle: got ready=%b start=%b busy=%b want 0 0 1", tag, s_ready, layer_start, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (layer_start !== 1'b1 || s_ready !== 1'b0)
      $display("[TB] FAIL %s start_rise: got start=%b ready=%b want 1 0", tag, layer_start, s_ready);
    else n_pass++;
  endtask

  // Controller model: done rises lat cycles after start, falls one cycle after start falls
  task automatic do_handshake(input int lat, input string tag);
    repeat (lat - 1) tick();
    n_checks++;
    if (layer_start !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0)
      $display("[TB] FAIL %s busy_hold: got start=%b busy=%b fd=%b want 1 1 0", tag, layer_start, busy, frame_done);
    else n_pass++;
    layer_done = 1'b1;
    tick();
    n_checks++;
    if (layer_start !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL %s start_fall: got start=%b fd=%b busy=%b want 0 0 1", tag, layer_start, frame_done, busy);
    else n_pass++;
    layer_done = 1'b0;
    tick();
    n_checks++;
    if (frame_done !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL %s frame_done_pulse: got fd=%b ready=%b busy=%b want 1 1 0", tag, frame_done, s_ready, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (frame_done !== 1'b0 || s_ready !== 1'b1)
      $display("[TB] FAIL %s frame_done_end: got fd=%b ready=%b want 0 1", tag, frame_done, s_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (s_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 8'd0 ||
        layer_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || resync_err !== 1'b0)
      $display("[TB] FAIL reset_values: got ready=%b en=%b addr=%0d data=%0d start=%b busy=%b fd=%b err=%b want all 0",
               s_ready, wr_en, wr_addr, wr_data, layer_start, busy, frame_done, resync_err);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL reset_release: got ready=%b busy=%b want 1 0", s_ready, busy);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    feed_beats(900, 1'b1, 0, 1'b0, "full");
    expect_launch("full");
  endtask

  task automatic test_handshake();
    do_handshake(50, "handshake");
  endtask

  task automatic test_garbage();
    layer_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_sof   = 1'b0;
      s_data  = 8'(8'hA0 + k);
      tick();
      n_checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || layer_start !== 1'b0 || s_ready !== 1'b1)
        $display("[TB] FAIL garbage beat %0d: got en=%b busy=%b start=%b ready=%b want 0 0 0 1",
                 k, wr_en, busy, layer_start, s_ready);
      else n_pass++;
    end
    s_valid    = 1'b0;
    layer_done = 1'b0;
    feed_beats(900, 1'b1, 0, 1'b0, "garbage_frame");
    expect_launch("garbage_frame");
    do_handshake(10, "garbage_frame");
  endtask

  task automatic test_bubbles();
    feed_beats(900, 1'b1, 0, 1'b1, "bubbles");
    expect_launch("bubbles");
    do_handshake(5, "bubbles");
  endtask

  task automatic test_resync();
    int base;
    base = start_rises;
    n_checks++;
    if (resync_err !== 1'b0) $display("[TB] FAIL resync_err_before: got %b want 0", resync_err);
    else n_pass++;
    feed_beats(300, 1'b1, 0, 1'b0, "resync_a");
    n_checks++;
    if (layer_start !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL resync_partial: got start=%b busy=%b want 0 1", layer_start, busy);
    else n_pass++;
    feed_beats(900, 1'b1, 0, 1'b0, "resync_b");
    n_checks++;
    if (resync_err !== 1'b1) $display("[TB] FAIL resync_err_set: got %b want 1", resync_err);
    else n_pass++;
    expect_launch("resync");
    repeat (5) tick();
    n_checks++;
    if (start_rises - base !== 1)
      $display("[TB] FAIL resync_start_count: got %0d want 1", start_rises - base);
    else n_pass++;
  endtask

  task automatic test_reset_in_busy();
    n_checks++;
    if (busy !== 1'b1 || layer_start !== 1'b1)
      $display("[TB] FAIL pre_reset_busy: got busy=%b start=%b want 1 1", busy, layer_start);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (layer_start !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || resync_err !== 1'b0)
      $display("[TB] FAIL reset_busy: got start=%b busy=%b ready=%b err=%b want 0 0 0 0",
               layer_start, busy, s_ready, resync_err);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL reset_busy_idle: got ready=%b busy=%b want 1 0", s_ready, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_handshake();
    test_garbage();
    test_bubbles();
    test_resync();
    test_reset_in_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
